perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 13 +
 rtl/perf_counter_cell.sv | 32 +++
 rtl/perf_counter_bank.sv | 62 ++++++
 tb/tb_perf_counter_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared constants and state type for the performance counter bank.
package perf_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int NUM_CNT = 8;
  localparam int EV_RETIRE = 0;
  localparam int EV_STALL = 1;
  localparam int EV_FLUSH = 2;
  localparam int EV_BRANCH = 3;
  localparam int EV_MISPREDICT = 4;
  localparam int EV_LOAD = 5;
  localparam int EV_STORE = 6;
  typedef enum logic [1:0] {IDLE, RUN, STREAM} state_t;
endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one event counter, clear beats increment.
// PERF_SATURATE_EN: hold at all-ones and raise sticky ovf; otherwise wrap with ovf tied low.
module perf_counter_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);
`ifdef PERF_SATURATE_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) ovf <= 1'b1;
      else cnt <= cnt + WIDTH'(1);
    end
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc) cnt <= cnt + WIDTH'(1);
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: 8 performance counters with snapshot-and-stream readout.
// Define PERF_SATURATE_EN for saturating counters with sticky overflow flags.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               perf_enable,
  input  logic [EV_STORE:0]  ev,
  input  logic               clear,
  input  logic               snap_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_idx,
  output logic [CNT_W-1:0]   out_data,
  output logic               busy,
  output logic [NUM_CNT-1:0] ovf
);
  state_t state, state_nx;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic [CNT_W-1:0] shadow [NUM_CNT];
  logic counting, snap, last;
  assign counting = perf_enable && state != IDLE;
  assign snap = snap_req && state != STREAM;
  assign last = out_ready && out_idx == 3'(NUM_CNT - 1);
  // counter 0 counts cycles, the rest follow their event strobe
  assign inc = {ev, 1'b1} & {NUM_CNT{counting}};
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cell
    perf_counter_cell #(.WIDTH(CNT_W)) u_cell (
      .clk(clk),
      .rst(rst),
      .inc(inc[i]),
      .clear(clear),
      .cnt(cnt[i]),
      .ovf(ovf[i])
    );
  end
  always_comb begin
    state_nx = state;
    if (state == STREAM) state_nx = last ? (perf_enable ? RUN : IDLE) : STREAM;
    else state_nx = snap_req ? STREAM : (perf_enable ? RUN : IDLE);
  end
  // shadow takes the pre-increment, pre-clear values on the capture edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      out_idx <= '0;
      shadow <= '{default: '0};
    end else begin
      state <= state_nx;
      if (snap) begin
        shadow <= cnt;
        out_idx <= '0;
      end else if (busy && out_ready) out_idx <= out_idx + 3'd1;
    end
  assign busy = state == STREAM;
  assign out_valid = busy;
  assign out_data = shadow[out_idx];
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed scenarios plus random traffic against a queue-based reference model.
module tb_perf_counter_bank;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic perf_enable = 1'b0;
  logic clear = 1'b0;
  logic snap_req = 1'b0;
  logic out_ready = 1'b0;
  logic [6:0] ev = '0;
  logic out_valid, busy;
  logic [2:0] out_idx;
  logic [W-1:0] out_data;
  logic [7:0] ovf;
  int n_chk = 0;
  int n_pass = 0;
  int m_cnt [8];
  bit [7:0] m_ovf;
  bit m_run, m_str;
  int q_idx [$];
  int q_dat [$];
  int got [8];
  int n_got;

  perf_counter_bank #(.CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .perf_enable(perf_enable),
    .ev(ev),
    .clear(clear),
    .snap_req(snap_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_data(out_data),
    .busy(busy),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
  endtask

  function automatic void model_reset();
    m_cnt = '{default: 0};
    m_ovf = '0;
    m_run = 1'b0;
    m_str = 1'b0;
    q_idx.delete();
    q_dat.delete();
  endfunction

  function automatic void bump(int k);
    if (!SAT) m_cnt[k] = (m_cnt[k] + 1) % (MAXV + 1);
    else if (m_cnt[k] == MAXV) m_ovf[k] = 1'b1;
    else m_cnt[k]++;
  endfunction

  // one clock: drive, compare against the model, advance the model, take the edge
  task automatic cycle(input bit en, input bit [6:0] e, input bit clr, input bit snp, input bit rdy);
    bit cnt_on;
    perf_enable = en;
    ev = e;
    clear = clr;
    snap_req = snp;
    out_ready = rdy;
    #1;
    check("valid", out_valid, m_str);
    check("busy", busy, m_str);
    check("ovf", ovf, m_ovf);
    if (m_str) begin
      check("idx", out_idx, q_idx[0]);
      check("data", out_data, q_dat[0]);
    end
    if (out_valid && rdy) begin
      got[out_idx] = int'(out_data);
      n_got++;
    end
    if (m_str) begin
      cnt_on = en;
      if (rdy) begin
        void'(q_idx.pop_front());
        void'(q_dat.pop_front());
        if (q_idx.size() == 0) begin
          m_str = 1'b0;
          m_run = en;
        end
      end
    end else begin
      cnt_on = m_run && en;
      if (snp) begin
        for (int k = 0; k < 8; k++) begin
          q_idx.push_back(k);
          q_dat.push_back(m_cnt[k]);
        end
        m_str = 1'b1;
      end else m_run = en;
    end
    if (clr) begin
      m_cnt = '{default: 0};
      m_ovf = '0;
    end else if (cnt_on) begin
      bump(0);
      for (int k = 1; k < 8; k++) if (e[k-1]) bump(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int en_n, input int stall_at, input int stall_len);
    int st;
    bit rdy;
    st = 0;
    n_got = 0;
    got = '{default: -1};
    for (int i = 0; i < 40 && m_str; i++) begin
      rdy = !(n_got == stall_at && st < stall_len);
      if (!rdy) begin
        check("stall_idx", out_idx, stall_at);
        check("stall_data", out_data, q_dat[0]);
        st++;
      end
      cycle(i < en_n, 7'h00, 1'b0, 1'b0, rdy);
    end
    check("drain_busy", busy, 0);
    check("drain_words", n_got, 8);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    perf_enable = 1'b0;
    ev = '0;
    clear = 1'b0;
    snap_req = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    // 10 counting cycles, retire on 4 of them
    cycle(1, 7'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, (i % 3 == 0) ? 7'h01 : 7'h00, 0, 0, 1);
    cycle(0, 7'h00, 0, 1, 1);
    drain(0, -1, 0);
    for (int k = 0; k < 8; k++) check("s1_word", got[k], k == 0 ? 10 : (k == 1 ? 4 : 0));
    // consumer stalls for 5 cycles mid-stream
    cycle(0, 7'h00, 0, 1, 1);
    drain(0, 3, 5);
    for (int k = 0; k < 8; k++) check("s2_word", got[k], k == 0 ? 10 : (k == 1 ? 4 : 0));
    // clear together with snap after 20 counts, then 3 counts during the stream
    cycle(1, 7'h00, 1, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 7'($urandom), 0, 0, 1);
    cycle(1, 7'($urandom), 1, 1, 1);
    drain(3, -1, 0);
    check("s3_first", got[0], 20);
    cycle(0, 7'h00, 0, 1, 1);
    drain(0, -1, 0);
    check("s3_second", got[0], 3);
    // disabled counters ignore events
    cycle(0, 7'h7F, 1, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 7'h7F, 0, 0, 1);
    cycle(0, 7'h7F, 0, 1, 1);
    drain(0, -1, 0);
    for (int k = 0; k < 8; k++) check("s5_word", got[k], 0);
    // 300 cycles overflow an 8-bit counter
    cycle(1, 7'h00, 1, 0, 1);
    for (int i = 0; i < 300; i++) cycle(1, 7'h00, 0, 0, 1);
    cycle(0, 7'h00, 0, 1, 1);
    drain(0, -1, 0);
    check("s4_idx0", got[0], SAT ? 255 : 44);
    check("s4_ovf0", ovf[0], SAT);
    // reset in the middle of a stream
    cycle(1, 7'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 7'h7F, 0, 0, 1);
    cycle(1, 7'h7F, 0, 1, 1);
    for (int i = 0; i < 20 && out_idx != 3; i++) cycle(1, 7'h7F, 0, 0, 1);
    check("s6_pre_idx", out_idx, 3);
    do_reset();
    cycle(1, 7'h7F, 0, 0, 1);
    cycle(0, 7'h00, 0, 1, 1);
    drain(0, -1, 0);
    for (int k = 0; k < 8; k++) check("s6_word", got[k], 0);
    // random traffic
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 7) != 0, 7'($urandom), $urandom_range(0, 40) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
